// File: rtl/aes_enc_stream_adapter.sv
// Stream adapter around a 128-bit AES encipher core: packs four 32-bit input
// words into a block, starts the core, waits for its result with a timeout,
// then streams the ciphertext out as four 32-bit words (MSW first).
module aes_enc_stream_adapter #(
    parameter int unsigned TIMEOUT_CYCLES = 128
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [31:0]  i_in_data,
    output logic         o_core_next,
    output logic [127:0] o_core_block,
    input  logic         i_core_ready,
    input  logic [127:0] i_core_result,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [31:0]  o_out_data,
    output logic         o_busy,
    output logic         o_err,
    input  logic         i_err_clr
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TCTR_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StLoad,
        StStart,
        StWaitLo,
        StWaitHi,
        StEmit
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [1:0]      r_wctr;
    logic [1:0]      w_wctr_next;
    logic [TW-1:0]   r_tctr;
    logic [TW-1:0]   w_tctr_next;
    logic [127:0]    r_core_block;
    logic [127:0]    r_out_blk;
    logic            r_err;
    logic            w_load_we;
    logic            w_capture;
    logic            w_timeout;

    // Next-state, counter updates and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_wctr_next  = r_wctr;
        w_tctr_next  = r_tctr;
        w_load_we    = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        o_in_ready   = 1'b0;
        o_core_next  = 1'b0;
        o_out_valid  = 1'b0;
        unique case (r_state)
            StLoad: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_load_we   = 1'b1;
                    w_wctr_next = r_wctr + 2'd1;
                    if (r_wctr == 2'd3) begin
                        w_state_next = StStart;
                    end
                end
            end
            StStart: begin
                // Only pulse next when the core is idle.
                if (i_core_ready) begin
                    o_core_next  = 1'b1;
                    w_tctr_next  = '0;
                    w_state_next = StWaitLo;
                end
            end
            StWaitLo: begin
                // Ready is still high (stale) the cycle after next; wait for it to fall.
                if (!i_core_ready) begin
                    w_tctr_next  = r_tctr + TW'(1);
                    w_state_next = StWaitHi;
                end else if (r_tctr == TCTR_LAST) begin
                    w_timeout = 1'b1;
                end else begin
                    w_tctr_next = r_tctr + TW'(1);
                end
            end
            StWaitHi: begin
                if (i_core_ready) begin
                    w_capture    = 1'b1;
                    w_wctr_next  = 2'd0;
                    w_state_next = StEmit;
                end else if (r_tctr == TCTR_LAST) begin
                    w_timeout = 1'b1;
                end else begin
                    w_tctr_next = r_tctr + TW'(1);
                end
            end
            StEmit: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_wctr_next = r_wctr + 2'd1;
                    if (r_wctr == 2'd3) begin
                        w_state_next = StLoad;
                    end
                end
            end
            default: begin
                w_state_next = StLoad;
            end
        endcase
        // Abort: drop the block and return to loading without emitting.
        if (w_timeout) begin
            w_wctr_next  = 2'd0;
            w_tctr_next  = '0;
            w_state_next = StLoad;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StLoad;
            r_wctr  <= 2'd0;
            r_tctr  <= '0;
        end else begin
            r_state <= w_state_next;
            r_wctr  <= w_wctr_next;
            r_tctr  <= w_tctr_next;
        end
    end

    // Plaintext assembly: word slot 0 lands in the most significant bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_core_block <= '0;
        end else if (w_load_we) begin
            unique case (r_wctr)
                2'd0: r_core_block[127:96] <= i_in_data;
                2'd1: r_core_block[95:64]  <= i_in_data;
                2'd2: r_core_block[63:32]  <= i_in_data;
                2'd3: r_core_block[31:0]   <= i_in_data;
                default: ;
            endcase
        end
    end

    // Ciphertext capture when the core reports completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_blk <= '0;
        end else if (w_capture) begin
            r_out_blk <= i_core_result;
        end
    end

    // Sticky timeout flag; clear wins over a simultaneous set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (i_err_clr) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    // Output word select; stable while wctr holds under backpressure.
    always_comb begin
        o_out_data = r_out_blk[127:96];
        unique case (r_wctr)
            2'd0: o_out_data = r_out_blk[127:96];
            2'd1: o_out_data = r_out_blk[95:64];
            2'd2: o_out_data = r_out_blk[63:32];
            2'd3: o_out_data = r_out_blk[31:0];
            default: ;
        endcase
    end

    assign o_core_block = r_core_block;
    assign o_busy       = (r_state != StLoad);
    assign o_err        = r_err;

endmodule

// File: tb/tb_aes_enc_stream_adapter.sv
// Scoreboard bench for aes_enc_stream_adapter with a behavioural core model.
module tb_aes_enc_stream_adapter;

    localparam int unsigned TO = 8;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         core_next;
    logic [127:0] core_block;
    logic         core_ready;
    logic [127:0] core_result;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         busy;
    logic         err;
    logic         err_clr;

    aes_enc_stream_adapter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_data     (in_data),
        .o_core_next   (core_next),
        .o_core_block  (core_block),
        .i_core_ready  (core_ready),
        .i_core_result (core_result),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data),
        .o_busy        (busy),
        .o_err         (err),
        .i_err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_next  = 0;
    int n_blocks = 0;
    logic [31:0]  exp_q[$];
    logic [127:0] blk_q[$];

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not expected / bound expired", name);
    endfunction

    // Stand-in for the encipher core: knows the FIPS-197 vector, scrambles otherwise.
    function automatic logic [127:0] cipher(input logic [127:0] b);
        if (b == FIPS_PT) return FIPS_CT;
        return {b[95:0], b[127:96]} ^ 128'h0123456789abcdef_fedcba9876543210
               ^ {4{b[31:0] + 32'h9e3779b9}};
    endfunction

    // ---------------- core model ----------------
    logic         core_hang;
    logic         force_busy;
    logic         long_lat;
    logic         core_rdy_q;
    logic [127:0] res_q;
    logic [127:0] cblk_q;
    int           ph;
    int           lat;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_rdy_q <= 1'b1;
            ph         <= 0;
            lat        <= 0;
            res_q      <= '0;
            cblk_q     <= '0;
        end else begin
            case (ph)
                0: if (core_next && !core_hang) begin
                    ph     <= 1;
                    cblk_q <= core_block;
                    lat    <= long_lat ? 4 : int'($urandom_range(1, 4));
                end
                1: begin
                    core_rdy_q <= 1'b0;   // ready stays high one cycle after next
                    ph         <= 2;
                end
                default: begin
                    if (lat <= 1) begin
                        core_rdy_q <= 1'b1;
                        res_q      <= cipher(cblk_q);
                        ph         <= 0;
                    end else begin
                        lat <= lat - 1;
                    end
                end
            endcase
        end
    end

    assign core_ready  = core_rdy_q & ~force_busy;
    assign core_result = core_rdy_q ? res_q : ~res_q;

    // ---------------- downstream ready ----------------
    logic bp_rand;
    logic rnd_ready;
    logic man_ready;
    assign out_ready = bp_rand ? rnd_ready : man_ready;

    initial begin
        rnd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        hold_pend;
        logic [31:0] hold_data;
        hold_pend = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hold_pend = 1'b0;
            end else begin
                if (core_next) begin
                    n_next++;
                    chk("next_needs_ready", core_ready, 1);
                    if (blk_q.size() == 0) fail_now("unexpected_core_next");
                    else chk("core_block", core_block, blk_q.pop_front());
                end
                if (out_valid) chk("no_load_emit_overlap", in_ready, 0);
                if (hold_pend) begin
                    chk("valid_held", out_valid, 1);
                    chk("data_held", out_data, hold_data);
                end
                hold_pend = out_valid && !out_ready;
                hold_data = out_data;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) fail_now("unexpected_out_word");
                    else chk("out_word", out_data, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send_block(input logic [127:0] blk, input bit sparse,
                              input bit push_exp, input bit exp_next);
        logic [127:0] ct;
        int guard;
        ct = cipher(blk);
        n_blocks++;
        blk_q.push_back(blk);
        if (push_exp) for (int w = 0; w < 4; w++) exp_q.push_back(ct[127 - 32*w -: 32]);
        @(posedge clk);
        #1;
        for (int w = 0; w < 4; w++) begin
            if (sparse && w > 0) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = blk[127 - 32*w -: 32];
            guard = 0;
            @(negedge clk);
            while (!in_ready && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 300) fail_now("in_ready_wait");
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("next_latency", core_next, exp_next);
        chk("in_ready_after_load", in_ready, 0);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) fail_now("drain_wait");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int n;
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
        man_ready = 1'b1; bp_rand = 1'b0;
        core_hang = 1'b0; force_busy = 1'b0; long_lat = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_core_next", core_next, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_core_block", core_block, 0);
        chk("rst_out_data", out_data, 0);

        // FIPS-197 known answer, full-rate emit.
        exp_q.push_back(32'h69c4e0d8); exp_q.push_back(32'h6a7b0430);
        exp_q.push_back(32'hd8cdb780); exp_q.push_back(32'h70b4c55a);
        send_block(FIPS_PT, 0, 0, 1);
        k = 0;
        while (!out_valid && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) fail_now("fips_out_valid_wait");
        n = 0;
        while (out_valid && n < 10) begin @(negedge clk); n++; end
        chk("emit_one_word_per_cycle", n, 4);
        chk("fips_drained", exp_q.size(), 0);

        // Backpressure on word 1 for five cycles.
        exp_q.push_back(32'h69c4e0d8); exp_q.push_back(32'h6a7b0430);
        exp_q.push_back(32'hd8cdb780); exp_q.push_back(32'h70b4c55a);
        send_block(FIPS_PT, 0, 0, 1);
        k = 0;
        while (!out_valid && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) fail_now("bp_out_valid_wait");
        @(posedge clk);
        #1 man_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_word1", out_data, 32'h6a7b0430);
        end
        @(posedge clk);
        #1 man_ready = 1'b1;
        wait_drain();

        // Timeout: the core never drops ready.
        core_hang = 1'b1;
        send_block({$urandom, $urandom, $urandom, $urandom}, 0, 0, 1);
        n = 0;
        while (!err && n < 40) begin @(negedge clk); n++; end
        chk("timeout_cycles", n, TO + 1);
        chk("timeout_back_in_load", busy, 0);
        chk("timeout_in_ready", in_ready, 1);
        @(negedge clk);
        chk("err_sticky", err, 1);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk("err_cleared", err, 0);
        core_hang = 1'b0;

        // Core busy when the last word loads, released three cycles later.
        force_busy = 1'b1;
        send_block({$urandom, $urandom, $urandom, $urandom}, 0, 1, 0);
        repeat (2) begin
            @(negedge clk);
            chk("no_next_while_busy", core_next, 0);
        end
        @(posedge clk);
        #1 force_busy = 1'b0;
        @(negedge clk);
        chk("next_on_release", core_next, 1);
        wait_drain();

        // Reset while waiting for the result.
        long_lat = 1'b1;
        send_block({$urandom, $urandom, $urandom, $urandom}, 0, 0, 1);
        k = 0;
        while (core_ready && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) fail_now("core_ready_fall_wait");
        @(posedge clk);
        #1;
        chk("in_wait_hi_busy", busy, 1);
        reset_n = 1'b0;
        exp_q.delete();
        blk_q.delete();
        @(negedge clk);
        chk("midrst_core_next", core_next, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_core_block", core_block, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        long_lat = 1'b0;
        send_block({$urandom, $urandom, $urandom, $urandom}, 0, 1, 1);
        send_block({$urandom, $urandom, $urandom, $urandom}, 1, 1, 1);
        wait_drain();

        // Random blocks, sparse input, random backpressure.
        bp_rand = 1'b1;
        repeat (16) begin
            send_block({$urandom, $urandom, $urandom, $urandom},
                       1'($urandom_range(0, 1)), 1, 1);
        end
        wait_drain();
        bp_rand = 1'b0;
        repeat (5) @(negedge clk);

        chk("core_next_count", n_next, n_blocks);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("blk_q_empty", blk_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_enc_stream_adapter.md
AES_ENC_STREAM_ADAPTER -- requirements
Module: aes_enc_stream_adapter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 128, maximum cycles allowed in the core-wait states before an abort; legal range 8..255.
REQ-002 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-003 reset_n  in  1  reset; asynchronous, active-low.
REQ-004 in_valid  in  1  input word valid.
REQ-005 in_ready  out  1  adapter accepts the input word this cycle.
REQ-006 in_data  in  32  plaintext word; the first word of a block maps to bits [127:96].
REQ-007 core_next  out  1  single-cycle start pulse to the encipher core.
REQ-008 core_block  out  128  assembled plaintext; held stable from the core_next cycle until the next block load begins.
REQ-009 core_ready  in  1  core idle/done flag; reset value 1; falls one cycle after next is sampled.
REQ-010 core_result  in  128  core ciphertext; valid while core_ready=1 after completion.
REQ-011 out_valid  out  1  output word valid.
REQ-012 out_ready  in  1  downstream accepts the output word.
REQ-013 out_data  out  32  ciphertext word; the first word is [127:96].
REQ-014 busy  out  1  high in every state except LOAD.
REQ-015 err  out  1  sticky timeout flag.
REQ-016 err_clr  in  1  clears err; takes priority over a simultaneous set.

Function
REQ-017 States: LOAD, START, WAIT_LO, WAIT_HI, EMIT. The block SHALL use a 2-bit word counter (wctr) and a timeout counter (tctr) sized for TIMEOUT_CYCLES.
REQ-018 LOAD: in_ready=1.
- On in_valid&in_ready, in_data is written to word slot wctr (slot 0=[127:96] ... slot 3=[31:0]) and wctr increments.
- When slot 3 is written, the FSM goes to START and wctr wraps to 0.
REQ-019 in_ready SHALL be 0 in all states other than LOAD; there is no overlap of load and emit.
REQ-020 START: core_next=1 for exactly one cycle, and only if core_ready=1.
- If core_ready=0, the FSM stays in START with core_next=0.
- After a pulse, the FSM goes to WAIT_LO and clears tctr.
REQ-021 WAIT_LO: the FSM waits for core_ready=0, then goes to WAIT_HI. This guards against the stale ready level in the cycle after next.
REQ-022 WAIT_HI: when core_ready=1, core_result is captured into a 128-bit output register, the FSM goes to EMIT, and wctr is cleared.
REQ-023 tctr increments each cycle in WAIT_LO/WAIT_HI. When tctr reaches TIMEOUT_CYCLES-1 without the exit condition, the block SHALL:
- set err
- discard the block
- clear wctr
- go to LOAD
- raise no out_valid
REQ-024 EMIT: out_valid=1 and out_data = output register word wctr.
- On out_valid&out_ready, wctr increments.
- After word 3 is accepted, the FSM goes to LOAD with wctr=0.
REQ-025 While out_valid=1 and out_ready=0, out_data SHALL be held stable; out_valid SHALL NOT drop before acceptance.
REQ-026 End-to-end latency: core_next asserts on the cycle after the 4th input handshake when core_ready=1. out_valid asserts on the cycle after core_ready is sampled high in WAIT_HI.
REQ-027 core_block and the output register SHALL change only by word writes in LOAD and the capture in WAIT_HI respectively.
REQ-028 err_clr has no effect on the FSM, counters or data.
REQ-029 Throughput SHALL be 1 input word/cycle in LOAD and 1 output word/cycle in EMIT with out_ready held high.

Reset
REQ-030 Asynchronous reset SHALL give:
- state LOAD, wctr=0, tctr=0
- core_block=0, output register=0
- core_next=0, out_valid=0, err=0, busy=0
- in_ready=1 from the first clock after deassertion
REQ-031 Reset asserted mid-operation (any state) SHALL abandon the block immediately. No core_next or out_valid pulse SHALL follow deassertion until a new 4-word load completes.

Verification
REQ-032 Scenario, FIPS-197 AES-128 with the real core and key 000102030405060708090a0b0c0d0e0f:
- stimulus: in words 00112233, 44556677, 8899aabb, ccddeeff
- response: one core_next pulse; out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a in order
REQ-033 Scenario, backpressure:
- stimulus: out_ready low for 5 cycles at word 1
- response: out_data stays 6a7b0430 with out_valid=1 throughout; no word is lost or duplicated
REQ-034 Scenario, timeout:
- stimulus: core model that never drops core_ready, TIMEOUT_CYCLES=8
- response: err=1 after 8 wait cycles; FSM back in LOAD; out_valid never high; err_clr pulse returns err to 0
REQ-035 Scenario, core busy at start:
- stimulus: core_ready=0 when the 4th word loads, releasing after 3 cycles
- response: core_next asserts exactly once, on the cycle after core_ready is sampled 1
REQ-036 Scenario, reset mid-operation:
- stimulus: reset_n pulsed low during WAIT_HI, then 2 blocks loaded back-to-back
- response: outputs match both blocks in order; no output from the aborted block
REQ-037 Scenario, sparse input:
- stimulus: in_valid toggling 1/0 during load
- response: exactly 4 handshakes form the block; in_ready=0 from START until the last output word is accepted
